ntps_const_bank: RTL and testbench
==================================

Name: ntps_const_bank

Overview:
- Parametrised successor to the fixed tie-off constants (VCC/GND/xlconstant style).
- Provides NUM_CH constant outputs, each DATA_W bits wide.
- Reset values come from a parameter. Values are runtime-reprogrammable through a 32-bit register interface.
- Updates use double buffering: writes land in shadow registers and move to the outputs atomically on a commit strobe.
- Sits beside the NTP datapath; drives mode/enable straps that were previously hard-wired.

Parameters:
- NUM_CH, 4, number of constant channels (1..16).
- DATA_W, 4, width of each channel (1..32).
- ADDR_W, 8, register address width; must satisfy 2**ADDR_W > NUM_CH.
- RESET_VALUE, {NUM_CH*DATA_W{1'b0}}, concatenated per-channel reset values; channel 0 occupies the LSBs.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- cs  in  1  register access strobe; one access per cycle.
- we  in  1  1 = write, 0 = read; qualified by cs.
- address  in  ADDR_W  register address.
- write_data  in  32  write value; bits above DATA_W are ignored.
- read_data  out  32  read value, registered.
- commit  in  1  single-cycle strobe: shadow registers to active registers.
- lock  in  1  when high, channel writes are rejected.
- dout  out  NUM_CH*DATA_W  active constant values; channel n is at [n*DATA_W +: DATA_W].
- pending  out  1  shadow differs from active by at least one uncommitted write.
- error  out  1  sticky flag for a rejected write.

Behaviour:
- Reset (sync, active-high; one clk edge with reset=1):
  - active and shadow registers = RESET_VALUE;
  - dout = RESET_VALUE;
  - read_data = 0, pending = 0, error = 0.
  - Reset asserted mid-sequence discards all uncommitted shadow writes. Reset overrides every other input in that cycle.
- Address map:
  - 0..NUM_CH-1: channel registers. Write targets shadow; read returns active.
  - NUM_CH: STATUS register. Read = {30'b0, error, pending}; writes are ignored.
  - Any other address: read returns 0; a write is rejected.
- Write (cs=1, we=1):
  - If address < NUM_CH and lock=0: shadow[address] <= write_data[DATA_W-1:0], and pending <= 1 on the next edge.
  - If lock=1 or the address is out of range: no register changes, and error <= 1.
  - A write to STATUS is ignored without raising error.
- Read (cs=1, we=0):
  - read_data is valid exactly one cycle after the access and holds until the next read.
  - Channel values are zero-extended to 32 bits.
  - A read of STATUS clears error on the same edge that captures read_data. The captured value shows the pre-clear error.
  - If an error-setting write and a STATUS read coincide, set wins and error stays 1. (A single port cannot do both in one cycle, so this case matters only for future multi-port use; implement set-priority.)
- Commit:
  - On the edge where commit=1, active <= shadow for all channels atomically. dout changes on that edge, so latency from the commit strobe is 1 cycle.
  - pending <= 0 unless a channel write is accepted in the same cycle.
  - A write in the commit cycle is not included: the commit copies pre-write shadow, the write lands in shadow, and pending stays 1.
  - Commit with pending=0 is legal and leaves values unchanged.
  - lock does not block commit.
- No glitches: dout comes directly from flops and changes only on commit or reset edges.
- No FSM beyond the pending/error flags. Each channel is a shadow register plus an active register.

Decomposition:
- Package ntps_const_pkg holds:
  - BUS_W = 32;
  - the status bit positions STATUS_PENDING_BIT = 0 and STATUS_ERROR_BIT = 1;
  - a function returning the STATUS address for a given NUM_CH.
- Sub-module ntps_const_chan: one channel's shadow and active registers. Ports are clk, reset, rst_val, wr_en, wr_data, commit, and value. Instantiate it NUM_CH times with a generate loop.
- The top level contains address decode, the read mux, and the pending/error flags.

Test Plan:
1. Reset with NUM_CH=4, DATA_W=4, RESET_VALUE=16'hA5C3 -> dout=16'hA5C3; read of addr 2 returns 32'h5; STATUS returns 0.
2. Write addr 1 = 32'hFFFF_FFF7, no commit -> dout unchanged and pending=1. Then pulse commit -> on the next edge dout[7:4]=4'h7, pending=0, and read of addr 1 returns 32'h7.
3. Write addr 3 = 0x9 in the same cycle as commit -> dout[15:12] keeps its old value and pending=1. A second commit -> dout[15:12]=4'h9.
4. lock=1, write addr 0 = 0xE -> shadow and dout unchanged, error=1. STATUS read returns 32'h2 and clears error; the next STATUS read returns 0.
5. Write addr 7 (out of range) -> error=1 and no channel changes. Read addr 7 -> read_data=0.
6. Write addr 0 = 0x1, then assert reset before commit -> dout=RESET_VALUE, pending=0. Commit after reset -> dout still equals RESET_VALUE.

Source files
------------

// File: rtl/ntps_const_pkg.sv
// ---------------------------------------------------------------------------
// ntps_const_pkg
// Shared definitions for the NTP constant bank:
//   BUS_W               - width of the register read/write data bus
//   STATUS_PENDING_BIT  - STATUS bit reporting uncommitted shadow writes
//   STATUS_ERROR_BIT    - STATUS bit reporting a rejected write (sticky)
//   status_addr()       - STATUS register address for a given channel count
// ---------------------------------------------------------------------------
package ntps_const_pkg;

  localparam int BUS_W              = 32;
  localparam int STATUS_PENDING_BIT = 0;
  localparam int STATUS_ERROR_BIT   = 1;

  // STATUS sits directly after the last channel register.
  function automatic int status_addr(input int num_ch);
    return num_ch;
  endfunction

endpackage : ntps_const_pkg

// File: rtl/ntps_const_chan.sv
// ---------------------------------------------------------------------------
// ntps_const_chan
// One double-buffered constant channel: a shadow register that takes
// register-interface writes and an active register that drives the output.
// Ports:
//   clk      - system clock, rising edge
//   reset    - synchronous active-high reset, loads rst_val into both regs
//   rst_val  - reset value for this channel
//   wr_en    - accepted write to this channel's shadow register
//   wr_data  - shadow write value
//   commit   - copy shadow to active
//   value    - active value, straight from a flop
// ---------------------------------------------------------------------------
module ntps_const_chan #(
  parameter int DATA_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] rst_val,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              commit,
  output logic [DATA_W-1:0] value
);

  logic [DATA_W-1:0] r_shadow;
  logic [DATA_W-1:0] r_active;

  // Both registers sample on the same edge, so a commit coinciding with a
  // write copies the pre-write shadow; the new write stays pending.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_shadow <= rst_val;
      r_active <= rst_val;
    end else begin
      if (wr_en) begin
        r_shadow <= wr_data;
      end
      if (commit) begin
        r_active <= r_shadow;
      end
    end
  end

  assign value = r_active;

endmodule : ntps_const_chan

// File: rtl/ntps_const_bank.sv
// ---------------------------------------------------------------------------
// ntps_const_bank
// Bank of NUM_CH runtime-programmable constant outputs replacing hard-wired
// tie-offs next to the NTP datapath. Writes go to shadow registers and are
// moved to the outputs atomically by a commit strobe.
// Ports:
//   clk, reset  - clock and synchronous active-high reset
//   cs, we      - register access strobe and write select
//   address     - register address (channels 0..NUM_CH-1, STATUS at NUM_CH)
//   write_data  - write value, only the low DATA_W bits are stored
//   read_data   - registered read value, valid one cycle after the access
//   commit      - shadow -> active for all channels
//   lock        - rejects channel writes while high (commit still works)
//   dout        - active values, channel n at [n*DATA_W +: DATA_W]
//   pending     - at least one write has not been committed yet
//   error       - sticky rejected-write flag, cleared by reading STATUS
// ---------------------------------------------------------------------------
module ntps_const_bank
  import ntps_const_pkg::*;
#(
  parameter int                         NUM_CH      = 4,
  parameter int                         DATA_W      = 4,
  parameter int                         ADDR_W      = 8,
  parameter logic [NUM_CH*DATA_W-1:0]   RESET_VALUE = '0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cs,
  input  logic                     we,
  input  logic [ADDR_W-1:0]        address,
  input  logic [BUS_W-1:0]         write_data,
  output logic [BUS_W-1:0]         read_data,
  input  logic                     commit,
  input  logic                     lock,
  output logic [NUM_CH*DATA_W-1:0] dout,
  output logic                     pending,
  output logic                     error
);

  localparam logic [ADDR_W-1:0] STATUS_ADDR = ADDR_W'(status_addr(NUM_CH));
  localparam logic [ADDR_W-1:0] NUM_CH_A    = ADDR_W'(NUM_CH);

  // -------------------------------------------------------------------------
  // Address decode
  // -------------------------------------------------------------------------
  logic w_wr;
  logic w_rd;
  logic w_in_range;
  logic w_is_status;
  logic w_wr_ok;
  logic w_wr_err;

  assign w_wr        = cs & we;
  assign w_rd        = cs & ~we;
  assign w_in_range  = (address < NUM_CH_A);
  assign w_is_status = (address == STATUS_ADDR);
  assign w_wr_ok     = w_wr & w_in_range & ~lock;
  // STATUS writes are silently dropped; everything else that is not an
  // accepted channel write counts as rejected.
  assign w_wr_err    = w_wr & ~w_is_status & (lock | ~w_in_range);

  // -------------------------------------------------------------------------
  // Channel registers
  // -------------------------------------------------------------------------
  logic [DATA_W-1:0] w_chan_val [NUM_CH];

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_chan
    logic w_chan_wr;
    assign w_chan_wr = w_wr_ok & (address == ADDR_W'(gi));

    ntps_const_chan #(
      .DATA_W (DATA_W)
    ) u_chan (
      .clk     (clk),
      .reset   (reset),
      .rst_val (RESET_VALUE[gi*DATA_W +: DATA_W]),
      .wr_en   (w_chan_wr),
      .wr_data (write_data[DATA_W-1:0]),
      .commit  (commit),
      .value   (w_chan_val[gi])
    );

    assign dout[gi*DATA_W +: DATA_W] = w_chan_val[gi];
  end

  // Upper write_data bits carry no meaning for narrow channels.
  if (DATA_W < BUS_W) begin : g_unused_wdata
    logic w_unused_wdata;
    assign w_unused_wdata = ^write_data[BUS_W-1:DATA_W];
  end

  // -------------------------------------------------------------------------
  // Read mux
  // -------------------------------------------------------------------------
  logic [BUS_W-1:0] w_rd_mux;
  logic [BUS_W-1:0] w_status_word;

  always_comb begin
    w_status_word                     = '0;
    w_status_word[STATUS_PENDING_BIT] = pending;
    w_status_word[STATUS_ERROR_BIT]   = error;
  end

  always_comb begin
    w_rd_mux = '0;
    if (w_is_status) begin
      w_rd_mux = w_status_word;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (address == ADDR_W'(i)) begin
          w_rd_mux = BUS_W'(w_chan_val[i]);
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Registered read data and status flags
  // -------------------------------------------------------------------------
  logic r_pending;
  logic r_error;
  logic [BUS_W-1:0] r_read_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_read_data <= '0;
    end else if (w_rd) begin
      r_read_data <= w_rd_mux;
    end
  end

  // An accepted write outranks a commit in the same cycle because that
  // write is not part of the committed snapshot.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pending <= 1'b0;
    end else if (w_wr_ok) begin
      r_pending <= 1'b1;
    end else if (commit) begin
      r_pending <= 1'b0;
    end
  end

  // Set wins over the read-to-clear of STATUS.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_error <= 1'b0;
    end else if (w_wr_err) begin
      r_error <= 1'b1;
    end else if (w_rd & w_is_status) begin
      r_error <= 1'b0;
    end
  end

  assign read_data = r_read_data;
  assign pending   = r_pending;
  assign error     = r_error;

endmodule : ntps_const_bank

// File: tb/tb_ntps_const_bank.sv
module tb_ntps_const_bank;

  localparam int          NUM_CH = 4;
  localparam int          DATA_W = 4;
  localparam int          ADDR_W = 8;
  localparam logic [15:0] RV     = 16'hA5C3;

  logic              clk = 1'b0;
  logic              reset;
  logic              cs;
  logic              we;
  logic [ADDR_W-1:0] address;
  logic [31:0]       write_data;
  logic [31:0]       read_data;
  logic              commit;
  logic              lock;
  logic [15:0]       dout;
  logic              pending;
  logic              error;

  int n_tests = 0;
  int n_fail  = 0;

  ntps_const_bank #(
    .NUM_CH      (NUM_CH),
    .DATA_W      (DATA_W),
    .ADDR_W      (ADDR_W),
    .RESET_VALUE (RV)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .cs         (cs),
    .we         (we),
    .address    (address),
    .write_data (write_data),
    .read_data  (read_data),
    .commit     (commit),
    .lock       (lock),
    .dout       (dout),
    .pending    (pending),
    .error      (error)
  );

  always #5 clk = ~clk;

  // One clock cycle with the given inputs; returns #1 after the edge with
  // all strobes idle again.
  task automatic cyc(input logic c, input logic w, input logic [7:0] a,
                     input logic [31:0] d, input logic cm, input logic lk,
                     input logic rs);
    cs = c; we = w; address = a; write_data = d; commit = cm; lock = lk;
    reset = rs;
    @(posedge clk);
    #1;
    cs = 1'b0; we = 1'b0; commit = 1'b0; lock = 1'b0; reset = 1'b0;
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    cyc(1'b1, 1'b1, a, d, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic rd(input logic [7:0] a);
    cyc(1'b1, 1'b0, a, 32'h0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_commit();
    cyc(1'b0, 1'b0, 8'h0, 32'h0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    cyc(1'b0, 1'b0, 8'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    n_tests++;
    if (dout !== RV) begin
      n_fail++; $display("FAIL reset_dout got %h want %h", dout, RV);
    end
    n_tests++;
    if (read_data !== 32'h0 || pending !== 1'b0 || error !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_flags got rd=%h p=%b e=%b want 0/0/0",
               read_data, pending, error);
    end
    rd(8'd2);
    n_tests++;
    if (read_data !== 32'h5) begin
      n_fail++; $display("FAIL reset_rd_ch2 got %h want %h", read_data, 32'h5);
    end
    rd(8'd4);
    n_tests++;
    if (read_data !== 32'h0) begin
      n_fail++; $display("FAIL reset_status got %h want %h", read_data, 32'h0);
    end
  endtask

  task automatic test_write_commit();
    wr(8'd1, 32'hFFFF_FFF7);
    n_tests++;
    if (dout !== 16'hA5C3 || pending !== 1'b1) begin
      n_fail++;
      $display("FAIL wr_no_commit got dout=%h p=%b want A5C3/1", dout, pending);
    end
    do_commit();
    n_tests++;
    if (dout !== 16'hA573 || pending !== 1'b0) begin
      n_fail++;
      $display("FAIL commit got dout=%h p=%b want A573/0", dout, pending);
    end
    rd(8'd1);
    n_tests++;
    if (read_data !== 32'h7) begin
      n_fail++; $display("FAIL rd_ch1 got %h want %h", read_data, 32'h7);
    end
    // read_data holds through idle cycles
    cyc(1'b0, 1'b0, 8'd3, 32'h0, 1'b0, 1'b0, 1'b0);
    n_tests++;
    if (read_data !== 32'h7) begin
      n_fail++; $display("FAIL rd_hold got %h want %h", read_data, 32'h7);
    end
  endtask

  task automatic test_write_during_commit();
    cyc(1'b1, 1'b1, 8'd3, 32'h9, 1'b1, 1'b0, 1'b0);
    n_tests++;
    if (dout !== 16'hA573 || pending !== 1'b1) begin
      n_fail++;
      $display("FAIL wr_in_commit got dout=%h p=%b want A573/1", dout, pending);
    end
    do_commit();
    n_tests++;
    if (dout !== 16'h9573 || pending !== 1'b0) begin
      n_fail++;
      $display("FAIL second_commit got dout=%h p=%b want 9573/0", dout, pending);
    end
  endtask

  task automatic test_lock();
    cyc(1'b1, 1'b1, 8'd0, 32'hE, 1'b0, 1'b1, 1'b0);
    n_tests++;
    if (dout !== 16'h9573 || error !== 1'b1 || pending !== 1'b0) begin
      n_fail++;
      $display("FAIL lock_wr got dout=%h e=%b p=%b want 9573/1/0",
               dout, error, pending);
    end
    rd(8'd4);
    n_tests++;
    if (read_data !== 32'h2 || error !== 1'b0) begin
      n_fail++;
      $display("FAIL status_clear got rd=%h e=%b want 2/0", read_data, error);
    end
    rd(8'd4);
    n_tests++;
    if (read_data !== 32'h0) begin
      n_fail++; $display("FAIL status_again got %h want %h", read_data, 32'h0);
    end
    // shadow of ch0 must not have taken the locked write
    do_commit();
    n_tests++;
    if (dout !== 16'h9573) begin
      n_fail++; $display("FAIL lock_shadow got %h want %h", dout, 16'h9573);
    end
    // lock does not block commit
    wr(8'd2, 32'hB);
    cyc(1'b0, 1'b0, 8'h0, 32'h0, 1'b1, 1'b1, 1'b0);
    n_tests++;
    if (dout !== 16'h9B73 || pending !== 1'b0 || error !== 1'b0) begin
      n_fail++;
      $display("FAIL commit_locked got dout=%h p=%b e=%b want 9B73/0/0",
               dout, pending, error);
    end
  endtask

  task automatic test_out_of_range();
    wr(8'd7, 32'h3);
    n_tests++;
    if (error !== 1'b1 || pending !== 1'b0 || dout !== 16'h9B73) begin
      n_fail++;
      $display("FAIL oor_wr got e=%b p=%b dout=%h want 1/0/9B73",
               error, pending, dout);
    end
    rd(8'd7);
    n_tests++;
    if (read_data !== 32'h0) begin
      n_fail++; $display("FAIL oor_rd got %h want %h", read_data, 32'h0);
    end
    rd(8'd4);
    n_tests++;
    if (read_data !== 32'h2) begin
      n_fail++; $display("FAIL oor_status got %h want %h", read_data, 32'h2);
    end
    // STATUS write is ignored and raises no error
    wr(8'd4, 32'hFFFF_FFFF);
    n_tests++;
    if (error !== 1'b0 || pending !== 1'b0) begin
      n_fail++;
      $display("FAIL status_wr got e=%b p=%b want 0/0", error, pending);
    end
  endtask

  task automatic test_reset_discard();
    wr(8'd0, 32'h1);
    n_tests++;
    if (pending !== 1'b1) begin
      n_fail++; $display("FAIL pre_reset_pending got %b want 1", pending);
    end
    // reset overrides a simultaneous write and commit
    cyc(1'b1, 1'b1, 8'd1, 32'h2, 1'b1, 1'b0, 1'b1);
    n_tests++;
    if (dout !== RV || pending !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid got dout=%h p=%b want %h/0", dout, pending, RV);
    end
    do_commit();
    n_tests++;
    if (dout !== RV) begin
      n_fail++; $display("FAIL commit_after_reset got %h want %h", dout, RV);
    end
  endtask

  task automatic test_back_to_back();
    wr(8'd0, 32'h4);
    wr(8'd1, 32'h5);
    wr(8'd2, 32'h6);
    wr(8'd3, 32'h8);
    n_tests++;
    if (dout !== RV || pending !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_pre got dout=%h p=%b want %h/1", dout, pending, RV);
    end
    do_commit();
    n_tests++;
    if (dout !== 16'h8654) begin
      n_fail++; $display("FAIL b2b_commit got %h want %h", dout, 16'h8654);
    end
    rd(8'd3);
    n_tests++;
    if (read_data !== 32'h8) begin
      n_fail++; $display("FAIL b2b_rd3 got %h want %h", read_data, 32'h8);
    end
    rd(8'd0);
    n_tests++;
    if (read_data !== 32'h4) begin
      n_fail++; $display("FAIL b2b_rd0 got %h want %h", read_data, 32'h4);
    end
  endtask

  initial begin
    reset = 1'b1; cs = 1'b0; we = 1'b0; address = '0; write_data = '0;
    commit = 1'b0; lock = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_write_commit();
    test_write_during_commit();
    test_lock();
    test_out_of_range();
    test_reset_discard();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_ntps_const_bank
